// File: rtl/outpkt_builder_pkg.sv
`default_nettype none
// ============================================================================
// outpkt_builder_pkg : type codes, header constants and FSM states for outpkt_builder
// Rev 1.0
// ============================================================================
package outpkt_builder_pkg;

  localparam logic [1:0] OUTPKT_TYPE_RESULT      = 2'd1;
  localparam logic [1:0] OUTPKT_TYPE_CMP_RESULT  = 2'd2;
  localparam logic [1:0] OUTPKT_TYPE_PACKET_DONE = 2'd3;
  localparam int         OUTPKT_TYPE_MSB         = 1;
  localparam int         OUTPKT_HDR_WORDS        = 3;
  localparam logic [7:0] OUTPKT_VERSION_DEFAULT  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_BODY = 3'd2,
`ifdef OUTPKT_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_ACK  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/outpkt_builder_checksum.sv
`default_nettype none
// ============================================================================
// outpkt_checksum : 32-bit word-sum accumulator with clear and inverted output,
// built only when OUTPKT_CHECKSUM_EN is defined.  Rev 1.0
// ============================================================================
`ifdef OUTPKT_CHECKSUM_EN
module outpkt_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] add_val,
  output logic [31:0] csum
);

  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + {16'b0, add_val};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign csum = ~sum_q;

endmodule
`endif
`default_nettype wire

// File: rtl/outpkt_builder.sv
`default_nettype none
// ============================================================================
// outpkt_builder : frames arbiter output items (header, body, optional checksum)
// into 16-bit words for the host FIFO. Macro OUTPKT_CHECKSUM_EN adds checksum.
// Rev 1.0
// ============================================================================
module outpkt_builder
  import outpkt_builder_pkg::*;
#(
  parameter int         PKT_NUM_WORDS  = 20,
  parameter int         HASH_NUM_WIDTH = 8,
  parameter logic [7:0] VERSION        = OUTPKT_VERSION_DEFAULT
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             empty,
  input  logic [OUTPKT_TYPE_MSB:0]         outpkt_type,
  input  logic [15:0]                      pkt_id,
  input  logic [HASH_NUM_WIDTH-1:0]        hash_num,
  input  logic [31:0]                      num_processed,
  output logic [$clog2(PKT_NUM_WORDS)-1:0] rd_addr,
  input  logic [15:0]                      din,
  output logic                             rd_en,
  output logic [15:0]                      fifo_dout,
  output logic                             fifo_wr_en,
  input  logic                             fifo_full,
  output logic                             err
);

  localparam int ADDR_W = $clog2(PKT_NUM_WORDS);

  state_e                     state_q, state_d;
  logic [OUTPKT_TYPE_MSB:0]   type_q, type_d;
  logic [15:0]                pkt_id_q, pkt_id_d;
  logic [HASH_NUM_WIDTH-1:0]  hash_q, hash_d;
  logic [31:0]                np_q, np_d;
  logic [15:0]                len_q, len_d;
  logic [15:0]                idx_q, idx_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
  logic                       err_q, err_d;
  logic                       emit;
  logic [15:0]                word;

`ifdef OUTPKT_CHECKSUM_EN
  logic [31:0] csum;

  assign emit = (state_q == ST_HDR) || (state_q == ST_BODY) || (state_q == ST_CSUM);

  // Only header/body words are summed; the sum is frozen while it is emitted.
  outpkt_checksum u_checksum (
    .clk     (CLK),
    .rst     (RST),
    .clr     (state_q == ST_IDLE),
    .add_en  (fifo_wr_en && (state_q != ST_CSUM)),
    .add_val (word),
    .csum    (csum)
  );
`else
  assign emit = (state_q == ST_HDR) || (state_q == ST_BODY);
`endif

  assign fifo_wr_en = emit & ~fifo_full;
  assign fifo_dout  = word;
  assign rd_addr    = rd_addr_q;
  assign err        = err_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    pkt_id_d  = pkt_id_q;
    hash_d    = hash_q;
    np_d      = np_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    word      = '0;
    rd_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (outpkt_type == 2'd0) begin
            err_d = 1'b1;
            rd_en = 1'b1;
          end else begin
            type_d    = outpkt_type;
            pkt_id_d  = pkt_id;
            hash_d    = hash_num;
            np_d      = num_processed;
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = ST_HDR;
            case (outpkt_type)
              OUTPKT_TYPE_RESULT:     len_d = 16'(PKT_NUM_WORDS);
              OUTPKT_TYPE_CMP_RESULT: len_d = 16'(PKT_NUM_WORDS + 1);
              default:                len_d = 16'd2;
            endcase
          end
        end
      end

      ST_HDR: begin
        case (idx_q[1:0])
          2'd0:    word = {6'b0, type_q, VERSION};
          2'd1:    word = pkt_id_q;
          default: word = len_q;
        endcase
        if (fifo_wr_en) begin
          if (idx_q == 16'(OUTPKT_HDR_WORDS - 1)) begin
            idx_d   = '0;
            state_d = ST_BODY;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end

      ST_BODY: begin
        // rd_addr tracks din-sourced words only, so the CMP hash word does not advance it.
        if (type_q == OUTPKT_TYPE_PACKET_DONE) begin
          word = (idx_q == 16'd0) ? np_q[15:0] : np_q[31:16];
        end else if (type_q == OUTPKT_TYPE_CMP_RESULT && idx_q == 16'd0) begin
          word = 16'(hash_q);
        end else begin
          word = din;
          if (fifo_wr_en) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
        if (fifo_wr_en && idx_q == len_q - 16'd1) begin
          idx_d     = '0;
          rd_addr_d = '0;
`ifdef OUTPKT_CHECKSUM_EN
          state_d   = ST_CSUM;
`else
          state_d   = ST_ACK;
`endif
        end else if (fifo_wr_en) begin
          idx_d = idx_q + 16'd1;
        end
      end

`ifdef OUTPKT_CHECKSUM_EN
      ST_CSUM: begin
        word = (idx_q == 16'd0) ? csum[15:0] : csum[31:16];
        if (fifo_wr_en) begin
          if (idx_q == 16'd1) begin
            idx_d   = '0;
            state_d = ST_ACK;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
`endif

      ST_ACK: begin
        rd_en   = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      type_q    <= '0;
      pkt_id_q  <= '0;
      hash_q    <= '0;
      np_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      pkt_id_q  <= pkt_id_d;
      hash_q    <= hash_d;
      np_q      <= np_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_outpkt_builder.sv
`default_nettype none
// ============================================================================
// tb_outpkt_builder : scoreboard bench; a packet-level reference model queues the
// expected word stream, a monitor checks every FIFO write.  Rev 1.0
// ============================================================================
module tb_outpkt_builder;

  localparam int PNW = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b1;
  logic [1:0]  outpkt_type = '0;
  logic [15:0] pkt_id = '0;
  logic [7:0]  hash_num = '0;
  logic [31:0] num_processed = '0;
  logic [4:0]  rd_addr;
  logic [15:0] din;
  logic        rd_en;
  logic [15:0] fifo_dout;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic        err;

  logic [15:0] mem [PNW];
  int          full_mode = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_cnt = 0;
  int          exp_acks = 0;

  typedef struct {
    logic [15:0] w;
    bit          chk_addr;
    logic [4:0]  addr;
  } exp_t;
  exp_t exp_q[$];

  outpkt_builder #(.PKT_NUM_WORDS(PNW), .HASH_NUM_WIDTH(8), .VERSION(8'h02)) dut (
    .CLK(clk), .RST(rst), .empty(empty), .outpkt_type(outpkt_type), .pkt_id(pkt_id),
    .hash_num(hash_num), .num_processed(num_processed), .rd_addr(rd_addr), .din(din),
    .rd_en(rd_en), .fifo_dout(fifo_dout), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .err(err)
  );

  always #5 clk = ~clk;

  always_comb din = (rd_addr < 5'(PNW)) ? mem[rd_addr] : 16'hDEAD;

  always @(posedge clk) begin
    #1;
    case (full_mode)
      1:       fifo_full = ~fifo_full;
      2:       fifo_full = 1'($urandom_range(0, 1));
      default: fifo_full = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every accepted FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fifo_dout), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fifo_dout", 32'(fifo_dout), 32'(e.w));
        if (e.chk_addr) check("rd_addr", 32'(rd_addr), 32'(e.addr));
      end
    end
    if (!rst && rd_en) ack_cnt++;
  end

  task automatic add_word(input logic [15:0] w, input bit c, input int a,
                          inout logic [31:0] sum);
    exp_t e;
    e.w = w; e.chk_addr = c; e.addr = 5'(a);
    exp_q.push_back(e);
    sum = sum + {16'b0, w};
  endtask

  // Reference model: the complete word stream of one item.
  task automatic push_pkt(input logic [1:0] t, input logic [15:0] id,
                          input logic [7:0] h, input logic [31:0] np);
    logic [31:0] sum;
    logic [15:0] len;
    sum = 0;
    len = (t == 2'd1) ? 16'(PNW) : (t == 2'd2) ? 16'(PNW + 1) : 16'd2;
    add_word({6'b0, t, 8'h02}, 1'b0, 0, sum);
    add_word(id, 1'b0, 0, sum);
    add_word(len, 1'b0, 0, sum);
    if (t == 2'd3) begin
      add_word(np[15:0], 1'b1, 0, sum);
      add_word(np[31:16], 1'b1, 0, sum);
    end else begin
      if (t == 2'd2) add_word({8'h00, h}, 1'b0, 0, sum);
      for (int i = 0; i < PNW; i++) add_word(mem[i], 1'b1, i, sum);
    end
`ifdef OUTPKT_CHECKSUM_EN
    begin
      logic [31:0] dummy;
      logic [31:0] cs;
      cs = ~sum;
      dummy = 0;
      add_word(cs[15:0], 1'b0, 0, dummy);
      add_word(cs[31:16], 1'b0, 0, dummy);
    end
`endif
  endtask

  task automatic present(input logic [1:0] t, input logic [15:0] id,
                         input logic [7:0] h, input logic [31:0] np);
    @(posedge clk); #1;
    outpkt_type = t; pkt_id = id; hash_num = h; num_processed = np;
    push_pkt(t, id, h, np);
    empty = 1'b0;
  endtask

  // Waits for rd_en; returns first-write cycle and rd_en cycle relative to presentation.
  task automatic finish_pkt(output int first, output int ack);
    int n;
    first = -1; ack = -1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (fifo_wr_en && first < 0) first = n;
      if (rd_en) begin ack = n; break; end
    end
    if (ack < 0) check("rd_en_timeout", 32'(n), 32'd0);
    check("words_left_at_ack", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_acks++;
    @(posedge clk); #1;
    empty = 1'b1;
    @(negedge clk);
    check("rd_en_one_cycle", 32'(rd_en), 32'd0);
  endtask

  task automatic run_pkt(input logic [1:0] t, input logic [15:0] id, input logic [7:0] h,
                         input logic [31:0] np, output int first, output int ack);
    present(t, id, h, np);
    finish_pkt(first, ack);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_dout"}, 32'(fifo_dout), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int first, ack, total, csw;
`ifdef OUTPKT_CHECKSUM_EN
    csw = 2;
`else
    csw = 0;
`endif
    for (int i = 0; i < PNW; i++) mem[i] = 16'hA000 + 16'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Directed RESULT: latency and length without back-pressure.
    run_pkt(2'd1, 16'h1234, 8'h00, 32'h0, first, ack);
    check("result_latency", 32'(first), 32'd1);
    check("result_span", 32'(ack - first), 32'(3 + PNW + csw));

    run_pkt(2'd2, 16'hBEEF, 8'h05, 32'h0, first, ack);
    check("cmp_span", 32'(ack - first), 32'(4 + PNW + csw));

    run_pkt(2'd3, 16'h00C3, 8'h00, 32'h0001_0002, first, ack);
    check("pd_span", 32'(ack - first), 32'(5 + csw));

    run_pkt(2'd3, 16'h0000, 8'h00, 32'h0000_0001, first, ack);

    // Alternating back-pressure: every word once, words + stalls cycles.
    full_mode = 1;
    run_pkt(2'd1, 16'h1234, 8'h00, 32'h0, first, ack);
    check("alt_full_span", 32'(ack - first), 32'(2 * (3 + PNW + csw) - 1));
    full_mode = 0;
    @(posedge clk);

    // Reset at body word 7; the still-pending item must be re-emitted in full.
    for (int i = 0; i < PNW; i++) mem[i] = 16'($urandom);
    present(2'd1, 16'h7777, 8'h00, 32'h0);
    total = exp_q.size();
    for (int n = 0; n < 200 && exp_q.size() > total - 10; n++) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    push_pkt(2'd1, 16'h7777, 8'h00, 32'h0);
    finish_pkt(first, ack);
    check("reemit_span", 32'(ack - first), 32'(3 + PNW + csw));

    // Randomized items under random back-pressure.
    full_mode = 2;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < PNW; i++) mem[i] = 16'($urandom);
      run_pkt(2'($urandom_range(1, 3)), 16'($urandom), 8'($urandom), $urandom, first, ack);
    end
    full_mode = 0;

    // Invalid type: dropped with an immediate rd_en and a sticky err.
    @(posedge clk); #1;
    outpkt_type = 2'd0; empty = 1'b0;
    @(negedge clk);
    check("bad_type_rd_en", 32'(rd_en), 32'd1);
    check("bad_type_no_write", 32'(fifo_wr_en), 32'd0);
    exp_acks++;
    @(posedge clk); #1 empty = 1'b1;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    run_pkt(2'd3, 16'h0042, 8'h00, 32'hCAFE_F00D, first, ack);
    check("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);

    check("ack_count", 32'(ack_cnt), 32'(exp_acks));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
